// File: rtl/bo_fp_pkg.sv
// Shared binary32 divider definitions: field widths, FSM states, operand classes.
package bo_fp_pkg;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int DIV_STEPS = 26;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, PACK, DONE} state_e;
  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_e;

  // Exponent 0 is classed as zero, so denormals flush to zero.
  function automatic cls_e classify(input logic [EXP_W+MAN_W-1:0] x);
    if (x[EXP_W+MAN_W-1:MAN_W] == '0) return CLS_ZERO;
    if (x[EXP_W+MAN_W-1:MAN_W] == '1) return (x[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction
endpackage

// File: rtl/bo_mant_div_seq.sv
// Restoring mantissa divider: q = floor((ma<<25)/mb), one quotient bit per step.
module bo_mant_div_seq
  import bo_fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [25:0] q,
  output logic [23:0] r,
  output logic        last
);
  logic [23:0] r_q, r_d;
  logic [25:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        nb_q, nb_d;
  logic [24:0] t;

  // Partial remainder starts at ma>>1; ma[0] is the only nonzero dividend bit left to shift in.
  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    nb_d  = nb_q;
    t     = {r_q, nb_q};
    if (load) begin
      r_d   = {1'b0, ma[23:1]};
      nb_d  = ma[0];
      q_d   = '0;
      cnt_d = '0;
    end else if (step) begin
      nb_d  = 1'b0;
      cnt_d = cnt_q + 5'd1;
      if (t >= {1'b0, mb}) begin
        r_d = 24'(t - {1'b0, mb});
        q_d = {q_q[24:0], 1'b1};
      end else begin
        r_d = t[23:0];
        q_d = {q_q[24:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      nb_q  <= 1'b0;
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      nb_q  <= nb_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign last = (cnt_q == 5'(DIV_STEPS - 1));
endmodule

// File: rtl/bo_div_floatingpoint.sv
// Multi-cycle binary32 divider, fixed 29-cycle latency for every operand class.
// Rounding: BO_DIV_RNE_EN defined -> round-to-nearest-even, otherwise truncate.
module bo_div_floatingpoint
  import bo_fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        div_by_zero_flag
);
  state_e state_q, state_d;
  logic [31:0] a_q, b_q, spec_res_q, spec_res_d, result_q, res_d;
  logic sgn, sign_q, spec_q, spec_d, dbz_q, dbz_d;
  logic signed [9:0] e_q, e_un, e_n, e_p;
  logic [23:0] mant_q, mant_n, mant_p, r;
  logic [25:0] q;
  logic g_q, g_n, s_q, s_n, div_last;
  logic ovf_q, unf_q, dbzf_q, ovf_d, unf_d;
  logic unused_bits;
  cls_e ca, cb;

  assign sgn  = a_q[31] ^ b_q[31];
  assign ca   = classify(a_q[30:0]);
  assign cb   = classify(b_q[30:0]);
  assign e_un = signed'({2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'(BIAS));

  bo_mant_div_seq u_div (
    .clk  (clk),
    .reset(reset),
    .load (state_q == UNPACK),
    .step (state_q == DIVIDE),
    .ma   ({|a_q[30:23], a_q[22:0]}),
    .mb   ({|b_q[30:23], b_q[22:0]}),
    .q    (q),
    .r    (r),
    .last (div_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = UNPACK;
      UNPACK:  state_d = DIVIDE;
      DIVIDE:  if (div_last) state_d = NORM;
      NORM:    state_d = PACK;
      PACK:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Special operands are resolved up front; the datapath still runs so latency is fixed.
  always_comb begin
    spec_d     = 1'b1;
    dbz_d      = 1'b0;
    spec_res_d = QNAN;
    if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
        (ca == CLS_INF && cb == CLS_INF))
      spec_res_d = QNAN;
    else if (ca == CLS_INF)
      spec_res_d = {sgn, 8'hFF, 23'h0};
    else if (cb == CLS_ZERO) begin
      spec_res_d = {sgn, 8'hFF, 23'h0};
      dbz_d      = 1'b1;
    end else if (cb == CLS_INF || ca == CLS_ZERO)
      spec_res_d = {sgn, 31'h0};
    else
      spec_d = 1'b0;
  end

  always_comb begin
    if (q[25]) begin
      mant_n = q[25:2];
      g_n    = q[1];
      s_n    = q[0] | (|r);
      e_n    = e_q;
    end else begin
      mant_n = q[24:1];
      g_n    = q[0];
      s_n    = |r;
      e_n    = e_q - 10'sd1;
    end
  end

`ifdef BO_DIV_RNE_EN
  logic [24:0] sum;
  // A carry out can only yield exactly 2^24, so renormalizing is a shift plus e+1.
  always_comb begin
    sum = {1'b0, mant_q} + {24'b0, g_q & (s_q | mant_q[0])};
    if (sum[24]) begin
      mant_p = sum[24:1];
      e_p    = e_q + 10'sd1;
    end else begin
      mant_p = sum[23:0];
      e_p    = e_q;
    end
  end
  assign unused_bits = mant_p[23];
`else
  assign mant_p      = mant_q;
  assign e_p         = e_q;
  assign unused_bits = ^{mant_p[23], g_q, s_q};
`endif

  always_comb begin
    res_d = {sign_q, e_p[7:0], mant_p[22:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (spec_q)
      res_d = spec_res_q;
    else if (e_p >= 10'sd255) begin
      res_d = {sign_q, 8'hFF, 23'h0};
      ovf_d = 1'b1;
    end else if (e_p <= 10'sd0) begin
      res_d = {sign_q, 31'h0};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      e_q        <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      dbz_q      <= 1'b0;
      mant_q     <= '0;
      g_q        <= 1'b0;
      s_q        <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dbzf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          a_q <= A;
          b_q <= B;
        end
        UNPACK: begin
          sign_q     <= sgn;
          e_q        <= e_un;
          spec_q     <= spec_d;
          spec_res_q <= spec_res_d;
          dbz_q      <= dbz_d;
        end
        NORM: begin
          mant_q <= mant_n;
          g_q    <= g_n;
          s_q    <= s_n;
          e_q    <= e_n;
        end
        PACK: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          dbzf_q   <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign result           = result_q;
  assign done             = (state_q == DONE);
  assign busy             = (state_q != IDLE) && (state_q != DONE);
  assign overflow_flag    = ovf_q;
  assign underflow_flag   = unf_q;
  assign div_by_zero_flag = dbzf_q;
endmodule
